// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot iteration engine.
package mandel_pkg;

    localparam int unsigned FIX_DATA_W = 32;
    localparam int unsigned FIX_FRAC_W = 28;

    typedef logic signed [FIX_DATA_W-1:0]   fix_t;
    typedef logic signed [2*FIX_DATA_W-1:0] wide_t;

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    // 4.0 expressed with a 2*FRAC_W-bit fraction, i.e. the format of re*re.
    localparam wide_t ESCAPE_SQ = wide_t'(4) <<< (2 * FIX_FRAC_W);

    // Convert a real to the default fixed-point format, rounding toward -inf.
    function automatic fix_t to_fixed(input real v);
        return fix_t'($rtoi($floor(v * real'(longint'(1) << FIX_FRAC_W))));
    endfunction

endpackage

// File: rtl/mandel_step.sv
// One combinational Mandelbrot step: z' = z^2 + c plus the |z|^2 > 4 escape test on the current z.
module mandel_step #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 28
) (
    input  logic signed [DATA_W-1:0] re,
    input  logic signed [DATA_W-1:0] im,
    input  logic signed [DATA_W-1:0] c_re,
    input  logic signed [DATA_W-1:0] c_im,
    output logic signed [DATA_W-1:0] next_re,
    output logic signed [DATA_W-1:0] next_im,
    output logic                     escape
);

    localparam int unsigned WIDE_W = 2 * DATA_W;
    typedef logic signed [WIDE_W-1:0] lwide_t;

    localparam logic [WIDE_W:0] EscapeSq = (WIDE_W + 1)'(4) << (2 * FRAC_W);

    lwide_t          xsq;
    lwide_t          ysq;
    lwide_t          xy;
    lwide_t          re_wide;
    lwide_t          im_wide;
    logic [WIDE_W:0] mag_sq;

    always_comb begin
        xsq     = lwide_t'(re) * lwide_t'(re);
        ysq     = lwide_t'(im) * lwide_t'(im);
        xy      = lwide_t'(re) * lwide_t'(im);
        re_wide = (xsq - ysq) >>> FRAC_W;
        // (2*re*im) >>> FRAC_W is the same floor as (re*im) >>> (FRAC_W-1).
        im_wide = xy >>> (FRAC_W - 1);
        next_re = re_wide[DATA_W-1:0] + c_re;
        next_im = im_wide[DATA_W-1:0] + c_im;
        // Squares are non-negative, so an extra zero bit makes the sum overflow-free.
        mag_sq  = {1'b0, xsq} + {1'b0, ysq};
        escape  = mag_sq > EscapeSq;
    end

endmodule

// File: rtl/mandel_iter_engine.sv
// Fixed-point Mandelbrot escape-count engine, one job in flight, valid/ready on both sides.
// Optional MANDEL_ITER_ABORT_EN adds an abort input that drops the current job.
module mandel_iter_engine
    import mandel_pkg::*;
#(
    parameter int unsigned DATA_W   = FIX_DATA_W,
    parameter int unsigned FRAC_W   = FIX_FRAC_W,
    parameter int unsigned MAX_ITER = 1000,
    parameter int unsigned ITER_W   = $clog2(MAX_ITER + 1),
    parameter int unsigned COORD_W  = 16
) (
    input  logic               sync_clk,
    input  logic               sync_rst,
`ifdef MANDEL_ITER_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_c_re,
    input  logic [DATA_W-1:0]  in_c_im,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ITER_W-1:0]  out_n,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               busy
);

    localparam logic [ITER_W-1:0] LastIter = ITER_W'(MAX_ITER - 1);

    state_e                    state_q;
    logic signed [DATA_W-1:0]  c_re_q;
    logic signed [DATA_W-1:0]  c_im_q;
    logic signed [DATA_W-1:0]  re_q;
    logic signed [DATA_W-1:0]  im_q;
    logic [ITER_W-1:0]         i_q;
    logic [ITER_W-1:0]         out_n_q;
    logic [COORD_W-1:0]        out_x_q;
    logic [COORD_W-1:0]        out_y_q;

    logic signed [DATA_W-1:0]  next_re;
    logic signed [DATA_W-1:0]  next_im;
    logic                      escape;

    mandel_step #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_step (
        .re      (re_q),
        .im      (im_q),
        .c_re    (c_re_q),
        .c_im    (c_im_q),
        .next_re (next_re),
        .next_im (next_im),
        .escape  (escape)
    );

    always_ff @(posedge sync_clk) begin
        if (sync_rst) begin
            state_q <= StIdle;
            c_re_q  <= '0;
            c_im_q  <= '0;
            re_q    <= '0;
            im_q    <= '0;
            i_q     <= '0;
            out_n_q <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
`ifdef MANDEL_ITER_ABORT_EN
        end else if (abort && (state_q != StIdle)) begin
            state_q <= StIdle;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        c_re_q  <= in_c_re;
                        c_im_q  <= in_c_im;
                        out_x_q <= in_x;
                        out_y_q <= in_y;
                        re_q    <= '0;
                        im_q    <= '0;
                        i_q     <= '0;
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    if (escape) begin
                        out_n_q <= i_q;
                        state_q <= StDone;
                    end else if (i_q == LastIter) begin
                        out_n_q <= '0;
                        state_q <= StDone;
                    end else begin
                        re_q <= next_re;
                        im_q <= next_im;
                        i_q  <= i_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_n     = out_n_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;

endmodule
